// File: rtl/pbus_initiator.sv
// pbus_initiator: turns single outstanding core load/store requests into strobed peripheral-bus accesses
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   req_valid/req_ready              core request handshake (ready only in IDLE)
//   req_we, req_addr, req_wdata, req_be   request: store flag, byte offset, store data, byte enables
//   rsp_valid/rsp_ready              response handshake
//   rsp_rdata, rsp_err               load data (0 for stores), reject flag
//   pbus_addr, pbus_wr_en, pbus_rd_en, pbus_wdata, pbus_rdata   peripheral bus
//
// Build option: PBUS_RMW_EN enables read-modify-write for partial byte-enable stores;
// without it such stores are rejected with rsp_err and no bus access.
module pbus_initiator #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] pbus_addr,
    output logic              pbus_wr_en,
    output logic              pbus_rd_en,
    output logic [31:0]       pbus_wdata,
    input  logic [31:0]       pbus_rdata
);
    typedef enum logic [2:0] {
        IDLE, RD, WR, RESP
`ifdef PBUS_RMW_EN
        , RMW_RD
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-3:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              unused_addr_lsb;
`ifdef PBUS_RMW_EN
    logic [3:0]        be_q, be_d;
    logic [31:0]       merged;
`endif

    // byte offset bits never reach the bus
    assign unused_addr_lsb = ^req_addr[1:0];

`ifdef PBUS_RMW_EN
    always_comb begin
        merged = '0;
        for (int i = 0; i < 4; i++)
            merged[i*8 +: 8] = be_q[i] ? wdata_q[i*8 +: 8] : pbus_rdata[i*8 +: 8];
    end
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
`ifdef PBUS_RMW_EN
        be_d    = be_q;
`endif
        case (state_q)
            IDLE: if (req_valid) begin
                addr_d  = req_addr[ADDR_W-1:2];
                wdata_d = req_wdata;
                rdata_d = '0;
                err_d   = 1'b0;
`ifdef PBUS_RMW_EN
                be_d    = req_be;
`endif
                if (!req_we) state_d = RD;
                else if (req_be == 4'hF) state_d = WR;
                else if (req_be == 4'h0) state_d = RESP;
                else begin
`ifdef PBUS_RMW_EN
                    state_d = RMW_RD;
`else
                    state_d = RESP;
                    err_d   = 1'b1;
`endif
                end
            end
            RD: begin
                rdata_d = pbus_rdata;
                state_d = RESP;
            end
`ifdef PBUS_RMW_EN
            RMW_RD: begin
                wdata_d = merged;
                state_d = WR;
            end
`endif
            WR:      state_d = RESP;
            RESP:    state_d = rsp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
`ifdef PBUS_RMW_EN
            be_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef PBUS_RMW_EN
            be_q    <= be_d;
`endif
        end
    end

    // strobes decode straight from state_q so reset drops them asynchronously
`ifdef PBUS_RMW_EN
    assign pbus_rd_en = (state_q == RD) || (state_q == RMW_RD);
`else
    assign pbus_rd_en = (state_q == RD);
`endif
    assign pbus_wr_en = (state_q == WR);
    assign pbus_addr  = (pbus_rd_en || pbus_wr_en) ? {addr_q, 2'b00} : '0;
    assign pbus_wdata = pbus_wr_en ? wdata_q : '0;
    assign req_ready  = (state_q == IDLE);
    assign rsp_valid  = (state_q == RESP);
    assign rsp_rdata  = rsp_valid ? rdata_q : '0;
    assign rsp_err    = rsp_valid & err_q;
endmodule

// File: tb/tb_pbus_initiator.sv
// tb_pbus_initiator: directed self-checking bench for pbus_initiator
module tb_pbus_initiator;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [7:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [7:0]  pbus_addr;
    logic        pbus_wr_en;
    logic        pbus_rd_en;
    logic [31:0] pbus_wdata;
    logic [31:0] pbus_rdata;

    logic [31:0] mem [64];
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          n_vec = 0;
    int          n_err = 0;
    int          wr_snap;
    int          rd_snap;

    pbus_initiator #(.ADDR_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .pbus_addr(pbus_addr), .pbus_wr_en(pbus_wr_en), .pbus_rd_en(pbus_rd_en),
        .pbus_wdata(pbus_wdata), .pbus_rdata(pbus_rdata)
    );

    always #5 clk = ~clk;

    // slave: combinational read, write on the strobe edge
    assign pbus_rdata = mem[pbus_addr[7:2]];
    always @(posedge clk) begin
        if (pbus_wr_en) mem[pbus_addr[7:2]] <= pbus_wdata;
        if (pbus_wr_en) wr_cnt <= wr_cnt + 1;
        if (pbus_rd_en) rd_cnt <= rd_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // presents a request at the negedge; it is accepted on the following edge
    task automatic issue(input logic we, input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[1] = 32'hA5A5_0F0F;
        mem[3] = 32'h1122_3344;
        mem[5] = 32'h5555_AAAA;
        mem[7] = 32'hCAFE_F00D;

        // reset: request held but never accepted
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_be    = 4'hF;
        req_addr  = 8'h10;
        tick();
        tick();
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_strobes", 32'({pbus_rd_en, pbus_wr_en}), 32'd0);
        chk("rst_pbus_addr", 32'(pbus_addr), 32'h0);
        chk("rst_pbus_wdata", pbus_wdata, 32'h0);
        chk("rst_no_wr", 32'(wr_cnt), 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        rst_n     = 1'b1;

        // load at 0x04
        issue(1'b0, 8'h04, 32'h0, 4'h0);
        chk("ld_rd_en", 32'(pbus_rd_en), 32'd1);
        chk("ld_wr_en", 32'(pbus_wr_en), 32'd0);
        chk("ld_addr", 32'(pbus_addr), 32'h04);
        chk("ld_busy", 32'({req_ready, rsp_valid}), 32'd0);
        tick();
        chk("ld_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("ld_rdata", rsp_rdata, 32'hA5A5_0F0F);
        chk("ld_err", 32'(rsp_err), 32'd0);
        chk("ld_resp_strobes", 32'({pbus_rd_en, pbus_wr_en}), 32'd0);
        tick();
        chk("ld_idle", 32'({req_ready, rsp_valid}), 32'b10);

        // full store at 0x0B -> word 0x08
        issue(1'b1, 8'h0B, 32'hDEAD_BEEF, 4'hF);
        chk("st_wr_en", 32'(pbus_wr_en), 32'd1);
        chk("st_rd_en", 32'(pbus_rd_en), 32'd0);
        chk("st_addr", 32'(pbus_addr), 32'h08);
        chk("st_wdata", pbus_wdata, 32'hDEAD_BEEF);
        tick();
        chk("st_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("st_rdata", rsp_rdata, 32'h0);
        chk("st_err", 32'(rsp_err), 32'd0);
        chk("st_resp_wdata", pbus_wdata, 32'h0);
        chk("st_mem", mem[2], 32'hDEAD_BEEF);
        tick();

        // partial store at 0x0C
        rd_snap = rd_cnt;
        wr_snap = wr_cnt;
        issue(1'b1, 8'h0C, 32'h0000_AA00, 4'b0010);
`ifdef PBUS_RMW_EN
        chk("rmw_rd_en", 32'({pbus_rd_en, pbus_wr_en}), 32'b10);
        chk("rmw_rd_addr", 32'(pbus_addr), 32'h0C);
        tick();
        chk("rmw_wr_en", 32'({pbus_rd_en, pbus_wr_en}), 32'b01);
        chk("rmw_wdata", pbus_wdata, 32'h1122_AA44);
        tick();
        chk("rmw_rsp", 32'({rsp_valid, rsp_err}), 32'b10);
        chk("rmw_mem", mem[3], 32'h1122_AA44);
`else
        chk("rmw_no_strobe", 32'({pbus_rd_en, pbus_wr_en}), 32'd0);
        chk("rmw_rsp", 32'({rsp_valid, rsp_err}), 32'b11);
        chk("rmw_rdata", rsp_rdata, 32'h0);
        chk("rmw_mem", mem[3], 32'h1122_3344);
        chk("rmw_no_bus", 32'((rd_cnt - rd_snap) + (wr_cnt - wr_snap)), 32'd0);
`endif
        tick();
        chk("rmw_idle", 32'(req_ready), 32'd1);

        // be=0 store: response only
        rd_snap = rd_cnt;
        wr_snap = wr_cnt;
        issue(1'b1, 8'h14, 32'hFFFF_FFFF, 4'h0);
        chk("be0_rsp", 32'({rsp_valid, rsp_err}), 32'b10);
        chk("be0_no_strobe", 32'({pbus_rd_en, pbus_wr_en}), 32'd0);
        tick();
        chk("be0_no_bus", 32'((rd_cnt - rd_snap) + (wr_cnt - wr_snap)), 32'd0);
        chk("be0_mem", mem[5], 32'h5555_AAAA);

        // response backpressure with a second request waiting
        @(negedge clk);
        rsp_ready = 1'b0;
        issue(1'b0, 8'h04, 32'h0, 4'h0);
        tick();
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 8'h1C;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rdata", rsp_rdata, 32'hA5A5_0F0F);
            chk("bp_ready", 32'(req_ready), 32'd0);
            tick();
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        tick();
        chk("bp_hs_idle", 32'({req_ready, rsp_valid}), 32'b10);
        tick();
        req_valid = 1'b0;
        chk("bp_second_rd", 32'(pbus_rd_en), 32'd1);
        chk("bp_second_addr", 32'(pbus_addr), 32'h1C);
        tick();
        chk("bp_second_rdata", rsp_rdata, 32'hCAFE_F00D);
        tick();

        // reset during the first cycle after accepting a partial store
        wr_snap = wr_cnt;
        issue(1'b1, 8'h0C, 32'hBB00_0000, 4'b1000);
`ifdef PBUS_RMW_EN
        chk("mid_rd_before", 32'(pbus_rd_en), 32'd1);
`else
        chk("mid_rsp_before", 32'(rsp_valid), 32'd1);
`endif
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_strobes_drop", 32'({pbus_rd_en, pbus_wr_en}), 32'd0);
        chk("mid_rsp_drop", 32'(rsp_valid), 32'd0);
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("mid_idle", 32'({req_ready, rsp_valid}), 32'b10);
        chk("mid_no_wr", 32'(wr_cnt - wr_snap), 32'd0);
`ifdef PBUS_RMW_EN
        chk("mid_mem", mem[3], 32'h1122_AA44);
`else
        chk("mid_mem", mem[3], 32'h1122_3344);
`endif

        // recovers after reset
        issue(1'b0, 8'h08, 32'h0, 4'h0);
        tick();
        chk("post_rdata", rsp_rdata, 32'hDEAD_BEEF);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
